prl_tx_message_if: RTL
======================

# prl_tx_message_if

Policy-engine-to-protocol-layer transmit request interface. It accepts a one-cycle message request from the policy engine, registers and unpacks it into the field set used by the TX message constructor, and runs the request/ack/done handshake with the PRL TX state machine. It reports exactly one completion (or rejection) per accepted request back to the policy engine. It sits between the policy engine and the PRL TX path, mirroring the RX inform path.

## Interface
- TIMEOUT_CYC, 1024: max cycles in WAIT_DONE before a local timeout; legal range 2..65535.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pe2pl_tx_en  in  1  one-cycle request strobe
- pe2pl_tx_type  in  7  {message_type[1:0], header_type[4:0]}
- pe2pl_tx_sop_type  in  3  SOP type
- pe2pl_tx_info  in  55  packed data fields (layout below)
- pl2pe_tx_done  out  1  one-cycle completion strobe
- pl2pe_tx_result  out  3  completion result, valid with done, held after
- pl2pe_tx_reject  out  1  one-cycle strobe: request refused (busy)
- prl_tx_if_req  out  1  level request to TX state machine
- prl_tx_if_message_type  out  2
- prl_tx_if_header_type  out  5
- prl_tx_if_sop_type  out  3
- prl_tx_if_data_request_max_op_cur  out  10  info[9:0]
- prl_tx_if_data_request_op_cur  out  10  info[19:10]
- prl_tx_if_data_src_cap_max_cur  out  10  info[29:20]
- prl_tx_if_data_src_cap_voltage  out  10  info[39:30]
- prl_tx_if_data_src_cap_max_vol  out  8  info[47:40]
- prl_tx_if_data_request_pdo_type  out  1  info[48]; info[54:49] ignored
- prl_tx_st_ack  in  1  TX state machine took the request
- prl_tx_st_done  in  1  one-cycle transmission finished
- prl_tx_st_result  in  3  TX result, valid with done
- prl_tx_discard  in  1  one-cycle abort (incoming message)

## Operation
- States: IDLE, REQ, WAIT_DONE, REPORT.
- IDLE: pe2pl_tx_en -> latch type/sop/info into field registers, go REQ. prl_tx_discard is ignored.
- REQ: prl_tx_if_req=1. Outcomes:
  - discard -> REPORT, result 3'h5.
  - else ack -> WAIT_DONE, clear the timeout counter.
  - discard wins over ack in the same cycle.
- WAIT_DONE: counter increments each cycle. Outcomes:
  - done -> REPORT, result = prl_tx_st_result.
  - else discard -> REPORT, result 3'h5.
  - else counter == TIMEOUT_CYC-1 -> REPORT, result 3'h6.
  - Priority: done > discard > timeout.
- REPORT: pl2pe_tx_done=1 for one cycle. Next state is REQ if a pending request exists (pending is loaded into the field registers, slot freed), else IDLE.
- Field outputs hold their value until the next load. Counter is 16 bits; it is compared only in WAIT_DONE.
- pe2pl_tx_en outside IDLE is handled per Configuration.
- Discard (honoured in REQ or WAIT_DONE) also flushes the pending slot. A flushed request gets no completion.

## Timing
- Reset (rst=1 at a clk edge): state IDLE; every output 0, including all field outputs and pl2pe_tx_result; pending slot empty; counter 0.
- en at cycle N (IDLE) -> prl_tx_if_req and fields valid at N+1.
- ack at M -> req low at M+1.
- done at K -> pl2pe_tx_done at K+1. Earliest new req (from pending) at K+2.
- Rejection: pl2pe_tx_reject at N+1 for en at N.
- rst mid-transaction: abandons everything with no done strobe.

## Configuration
- PRL_TX_MSG_QUEUE_EN defined:
  - One-deep pending slot.
  - en while not IDLE with slot empty -> stored silently.
  - Slot full -> reject.
  - In REPORT, a stored request issues next; a new en in that same cycle goes to the slot if it was just freed, else reject.
- PRL_TX_MSG_QUEUE_EN undefined: any en outside IDLE -> reject. No pending logic is synthesized.

## Structure
- Package prl_tx_pkg holds:
  - state encoding;
  - result constants RES_DISCARDED=3'h5, RES_TIMEOUT=3'h6;
  - info field bit positions/widths, shared with the RX inform path.
- Sub-module prl_tx_req_buf: one-deep type/sop/info holding register with load/pop/flush/full. Instantiated only under PRL_TX_MSG_QUEUE_EN.

## Test plan
- Request type=7'h42, sop=3'h0, info[19:10]=10'h12C; ack 2 cycles later; done with result 3'h1 -> op_cur=10'h12C, req high then low after ack; done one cycle after st_done, result 3'h1.
- Discard in REQ coincident with ack -> done, result 3'h5, no WAIT_DONE entry.
- TIMEOUT_CYC=8; ack, no done -> done 8 cycles after entering WAIT_DONE, result 3'h6. Repeat with st_done on the final cycle -> result from st_result.
- Queue enabled: three ens while busy -> second stored, third rejected; second issues req 2 cycles after first done; two done strobes total.
- Queue disabled: en during WAIT_DONE -> reject one cycle later; in-flight completes unaffected.
- Assert rst in WAIT_DONE -> all outputs 0 next cycle, no done; fresh request then works.

Source files
------------

// File: rtl/prl_tx_pkg.sv
// prl_tx_pkg: shared definitions for the PRL TX message interface.
//   - FSM state encoding for prl_tx_message_if
//   - completion result codes generated locally (discard, timeout)
//   - bit positions / widths of the packed info word (also used by the RX inform path)
//   - tx_req_t: registered request record and a helper to build it from raw inputs
package prl_tx_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_REPORT    = 2'd3;

  localparam logic [2:0] RES_DISCARDED = 3'h5;
  localparam logic [2:0] RES_TIMEOUT   = 3'h6;

  localparam int unsigned INFO_W = 55;

  localparam int unsigned INFO_REQ_MAX_OP_CUR_LSB = 0;
  localparam int unsigned INFO_REQ_MAX_OP_CUR_W   = 10;
  localparam int unsigned INFO_REQ_OP_CUR_LSB     = 10;
  localparam int unsigned INFO_REQ_OP_CUR_W       = 10;
  localparam int unsigned INFO_SRC_MAX_CUR_LSB    = 20;
  localparam int unsigned INFO_SRC_MAX_CUR_W      = 10;
  localparam int unsigned INFO_SRC_VOLTAGE_LSB    = 30;
  localparam int unsigned INFO_SRC_VOLTAGE_W      = 10;
  localparam int unsigned INFO_SRC_MAX_VOL_LSB    = 40;
  localparam int unsigned INFO_SRC_MAX_VOL_W      = 8;
  localparam int unsigned INFO_REQ_PDO_TYPE_LSB   = 48;
  // Bits above the PDO type flag carry no field and are dropped at the input.
  localparam int unsigned INFO_USED_W             = 49;

  typedef struct packed {
    logic [6:0]             tx_type;
    logic [2:0]             sop;
    logic [INFO_USED_W-1:0] info;
  } tx_req_t;

  function automatic tx_req_t pack_req(logic [6:0] tx_type, logic [2:0] sop,
                                       logic [INFO_USED_W-1:0] info);
    tx_req_t r;
    r.tx_type = tx_type;
    r.sop     = sop;
    r.info    = info;
    return r;
  endfunction

endpackage

// File: rtl/prl_tx_req_buf.sv
// prl_tx_req_buf: one-deep holding register for a pending TX request.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_load            store i_type/i_sop/i_info, slot becomes full
//   i_pop             slot freed (contents already consumed by the owner)
//   i_flush           slot freed, contents dropped; wins over load and pop
//   i_type/i_sop/i_info  request to store
//   o_full            slot holds a request
//   o_type/o_sop/o_info  stored request
// A load together with a pop keeps the slot full with the new request.
module prl_tx_req_buf
  import prl_tx_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [6:0]             i_type,
  input  logic [2:0]             i_sop,
  input  logic [INFO_USED_W-1:0] i_info,
  output logic                   o_full,
  output logic [6:0]             o_type,
  output logic [2:0]             o_sop,
  output logic [INFO_USED_W-1:0] o_info
);

  tx_req_t r_data;
  logic    r_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= pack_req(i_type, i_sop, i_info);
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_type = r_data.tx_type;
  assign o_sop  = r_data.sop;
  assign o_info = r_data.info;

endmodule

// File: rtl/prl_tx_message_if.sv
// prl_tx_message_if: policy-engine to protocol-layer transmit request interface.
// Latches a one-cycle PE request, unpacks it for the TX message constructor, runs the
// req/ack/done handshake with the PRL TX state machine and returns one completion or
// rejection per request.
// Parameter TIMEOUT_CYC (2..65535): cycles spent in WAIT_DONE before a local timeout.
// Build option: define PRL_TX_MSG_QUEUE_EN to add a one-deep pending slot for requests
// arriving while busy; without it every request outside IDLE is rejected.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   pe2pl_tx_en/type/sop_type/info    PE request strobe and payload
//   pl2pe_tx_done/result              completion strobe, result (held after strobe)
//   pl2pe_tx_reject                   request refused (busy)
//   prl_tx_if_req + prl_tx_if_*       level request and unpacked fields to TX path
//   prl_tx_st_ack/done/result         TX state machine handshake
//   prl_tx_discard                    abort due to incoming message
module prl_tx_message_if
  import prl_tx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pe2pl_tx_en,
  input  logic [6:0]        pe2pl_tx_type,
  input  logic [2:0]        pe2pl_tx_sop_type,
  input  logic [INFO_W-1:0] pe2pl_tx_info,
  output logic              pl2pe_tx_done,
  output logic [2:0]        pl2pe_tx_result,
  output logic              pl2pe_tx_reject,
  output logic              prl_tx_if_req,
  output logic [1:0]        prl_tx_if_message_type,
  output logic [4:0]        prl_tx_if_header_type,
  output logic [2:0]        prl_tx_if_sop_type,
  output logic [9:0]        prl_tx_if_data_request_max_op_cur,
  output logic [9:0]        prl_tx_if_data_request_op_cur,
  output logic [9:0]        prl_tx_if_data_src_cap_max_cur,
  output logic [9:0]        prl_tx_if_data_src_cap_voltage,
  output logic [7:0]        prl_tx_if_data_src_cap_max_vol,
  output logic              prl_tx_if_data_request_pdo_type,
  input  logic              prl_tx_st_ack,
  input  logic              prl_tx_st_done,
  input  logic [2:0]        prl_tx_st_result,
  input  logic              prl_tx_discard
);

  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [1:0]  r_state, w_state_nxt;
  tx_req_t     r_req;
  logic [15:0] r_cnt;
  logic [2:0]  r_result, w_result_nxt;
  logic        r_reject, w_reject_nxt;
  logic        w_new_load;

  logic                   w_slot_full, w_slot_load, w_slot_pop;
  logic [6:0]             w_slot_type;
  logic [2:0]             w_slot_sop;
  logic [INFO_USED_W-1:0] w_slot_info;

  // Upper info bits have no destination field.
  logic w_unused_info;
  assign w_unused_info = ^pe2pl_tx_info[INFO_W-1:INFO_USED_W];

  assign w_new_load = (r_state == ST_IDLE) && pe2pl_tx_en;

  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    case (r_state)
      ST_IDLE: begin
        if (pe2pl_tx_en) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (prl_tx_discard) begin
          w_state_nxt  = ST_REPORT;
          w_result_nxt = RES_DISCARDED;
        end else if (prl_tx_st_ack) begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (prl_tx_st_done) begin
          w_state_nxt  = ST_REPORT;
          w_result_nxt = prl_tx_st_result;
        end else if (prl_tx_discard) begin
          w_state_nxt  = ST_REPORT;
          w_result_nxt = RES_DISCARDED;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt  = ST_REPORT;
          w_result_nxt = RES_TIMEOUT;
        end
      end
      default: begin  // ST_REPORT
        w_state_nxt = w_slot_full ? ST_REQ : ST_IDLE;
      end
    endcase
  end

`ifdef PRL_TX_MSG_QUEUE_EN
  logic w_slot_flush;

  // Only a discard that is actually honoured drops the pending request.
  assign w_slot_flush = prl_tx_discard &&
                        ((r_state == ST_REQ) ||
                         ((r_state == ST_WAIT_DONE) && !prl_tx_st_done));
  assign w_slot_pop   = (r_state == ST_REPORT) && w_slot_full;
  // In REPORT the slot only accepts if it is being emptied this same cycle.
  assign w_slot_load  = pe2pl_tx_en && (r_state != ST_IDLE) && !w_slot_flush &&
                        ((r_state == ST_REPORT) ? w_slot_full : !w_slot_full);
  assign w_reject_nxt = pe2pl_tx_en && (r_state != ST_IDLE) && !w_slot_load;

  prl_tx_req_buf u_req_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_slot_load),
    .i_pop   (w_slot_pop),
    .i_flush (w_slot_flush),
    .i_type  (pe2pl_tx_type),
    .i_sop   (pe2pl_tx_sop_type),
    .i_info  (pe2pl_tx_info[INFO_USED_W-1:0]),
    .o_full  (w_slot_full),
    .o_type  (w_slot_type),
    .o_sop   (w_slot_sop),
    .o_info  (w_slot_info)
  );
`else
  assign w_slot_full  = 1'b0;
  assign w_slot_load  = 1'b0;
  assign w_slot_pop   = 1'b0;
  assign w_slot_type  = '0;
  assign w_slot_sop   = '0;
  assign w_slot_info  = '0;
  assign w_reject_nxt = pe2pl_tx_en && (r_state != ST_IDLE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_req    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_reject <= w_reject_nxt;
      if (w_new_load) begin
        r_req <= pack_req(pe2pl_tx_type, pe2pl_tx_sop_type, pe2pl_tx_info[INFO_USED_W-1:0]);
      end else if (w_slot_pop) begin
        r_req <= pack_req(w_slot_type, w_slot_sop, w_slot_info);
      end
      if ((r_state == ST_REQ) && prl_tx_st_ack) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT_DONE) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign prl_tx_if_req   = (r_state == ST_REQ);
  assign pl2pe_tx_done   = (r_state == ST_REPORT);
  assign pl2pe_tx_result = r_result;
  assign pl2pe_tx_reject = r_reject;

  assign prl_tx_if_message_type = r_req.tx_type[6:5];
  assign prl_tx_if_header_type  = r_req.tx_type[4:0];
  assign prl_tx_if_sop_type     = r_req.sop;
  assign prl_tx_if_data_request_max_op_cur =
      r_req.info[INFO_REQ_MAX_OP_CUR_LSB +: INFO_REQ_MAX_OP_CUR_W];
  assign prl_tx_if_data_request_op_cur =
      r_req.info[INFO_REQ_OP_CUR_LSB +: INFO_REQ_OP_CUR_W];
  assign prl_tx_if_data_src_cap_max_cur =
      r_req.info[INFO_SRC_MAX_CUR_LSB +: INFO_SRC_MAX_CUR_W];
  assign prl_tx_if_data_src_cap_voltage =
      r_req.info[INFO_SRC_VOLTAGE_LSB +: INFO_SRC_VOLTAGE_W];
  assign prl_tx_if_data_src_cap_max_vol =
      r_req.info[INFO_SRC_MAX_VOL_LSB +: INFO_SRC_MAX_VOL_W];
  assign prl_tx_if_data_request_pdo_type = r_req.info[INFO_REQ_PDO_TYPE_LSB];

endmodule
